// File: rtl/alu.sv
// 32-bit execute-stage ALU: combines x and y under a 7-bit opcode; result registered into w.
// Opcode encodings mirror the shared CONSTANTS.vh map; guarded so either copy may be seen first.
`ifndef ALU_CONSTANTS_VH
`define ALU_CONSTANTS_VH
`define ADD  7'h00
`define SUB  7'h01
`define AND  7'h02
`define OR   7'h03
`define XOR  7'h04
`define SLL  7'h05
`define SRL  7'h06
`define SRA  7'h07
`define SLT  7'h08
`define SLTU 7'h09
`define MUL  7'h0A
`define MOVX 7'h0B
`define MOVY 7'h0C
`endif

module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] w
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] r_c;
    logic             slt_c;
    logic             sltu_c;

    // Shifts only look at the low bits of y, so a shift by WIDTH wraps to zero.
    assign shamt  = y[SHW-1:0];
    assign slt_c  = $signed(x) < $signed(y);
    assign sltu_c = x < y;

    // Result select; unmapped opcodes produce zero.
    always_comb begin
        r_c = '0;
        unique case (op)
            `ADD:    r_c = x + y;
            `SUB:    r_c = x - y;
            `AND:    r_c = x & y;
            `OR:     r_c = x | y;
            `XOR:    r_c = x ^ y;
            `SLL:    r_c = x << shamt;
            `SRL:    r_c = x >> shamt;
            `SRA:    r_c = WIDTH'($signed(x) >>> shamt);
            `SLT:    r_c = {(WIDTH-1)'(0), slt_c};
            `SLTU:   r_c = {(WIDTH-1)'(0), sltu_c};
            `MUL:    r_c = x * y;
            `MOVX:   r_c = x;
            `MOVY:   r_c = y;
            default: r_c = '0;
        endcase
    end

    // Result register with synchronous reset taking priority over the op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w <= '0;
        end else begin
            w <= r_c;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: one task per feature, hand-computed expected results.
`ifndef ALU_CONSTANTS_VH
`define ALU_CONSTANTS_VH
`define ADD  7'h00
`define SUB  7'h01
`define AND  7'h02
`define OR   7'h03
`define XOR  7'h04
`define SLL  7'h05
`define SRL  7'h06
`define SRA  7'h07
`define SLT  7'h08
`define SLTU 7'h09
`define MUL  7'h0A
`define MOVX 7'h0B
`define MOVY 7'h0C
`endif

module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [6:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] w;

    int unsigned pass_cnt;
    int unsigned total_cnt;

    alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (op),
        .x     (x),
        .y     (y),
        .w     (w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o;
        x  = a;
        y  = b;
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(`ADD, 32'd5, 32'd7);
        step();
        step();
        total_cnt++;
        if (w !== 32'h0) $display("FAIL reset_hold: got %h want %h", w, 32'h0);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (w !== 32'd12) $display("FAIL reset_release: got %h want %h", w, 32'd12);
        else pass_cnt++;
    endtask

    task automatic test_add_sub();
        drive(`ADD, 32'h1, 32'h2);
        step();
        total_cnt++;
        if (w !== 32'h3) $display("FAIL add_basic: got %h want %h", w, 32'h3);
        else pass_cnt++;
        drive(`ADD, 32'hFFFF_FFFF, 32'h1);
        step();
        total_cnt++;
        if (w !== 32'h0) $display("FAIL add_wrap: got %h want %h", w, 32'h0);
        else pass_cnt++;
        drive(`SUB, 32'h0, 32'h1);
        step();
        total_cnt++;
        if (w !== 32'hFFFF_FFFF) $display("FAIL sub_wrap: got %h want %h", w, 32'hFFFF_FFFF);
        else pass_cnt++;
        drive(`SUB, 32'd100, 32'd58);
        step();
        total_cnt++;
        if (w !== 32'd42) $display("FAIL sub_basic: got %h want %h", w, 32'd42);
        else pass_cnt++;
    endtask

    task automatic test_logic();
        drive(`AND, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        step();
        total_cnt++;
        if (w !== 32'h00F0_000F) $display("FAIL and: got %h want %h", w, 32'h00F0_000F);
        else pass_cnt++;
        drive(`OR, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        step();
        total_cnt++;
        if (w !== 32'hFFF0_0FFF) $display("FAIL or: got %h want %h", w, 32'hFFF0_0FFF);
        else pass_cnt++;
        drive(`XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        step();
        total_cnt++;
        if (w !== 32'hFF00_0FF0) $display("FAIL xor: got %h want %h", w, 32'hFF00_0FF0);
        else pass_cnt++;
    endtask

    task automatic test_shift();
        drive(`SLL, 32'h8000_0001, 32'd4);
        step();
        total_cnt++;
        if (w !== 32'h0000_0010) $display("FAIL sll: got %h want %h", w, 32'h0000_0010);
        else pass_cnt++;
        drive(`SRL, 32'h8000_0001, 32'd4);
        step();
        total_cnt++;
        if (w !== 32'h0800_0000) $display("FAIL srl: got %h want %h", w, 32'h0800_0000);
        else pass_cnt++;
        drive(`SRA, 32'h8000_0001, 32'd4);
        step();
        total_cnt++;
        if (w !== 32'hF800_0000) $display("FAIL sra_neg: got %h want %h", w, 32'hF800_0000);
        else pass_cnt++;
        drive(`SRA, 32'h4000_0000, 32'd4);
        step();
        total_cnt++;
        if (w !== 32'h0400_0000) $display("FAIL sra_pos: got %h want %h", w, 32'h0400_0000);
        else pass_cnt++;
        drive(`SLL, 32'h8000_0001, 32'h21);
        step();
        total_cnt++;
        if (w !== 32'h0000_0002) $display("FAIL sll_amt_mask: got %h want %h", w, 32'h0000_0002);
        else pass_cnt++;
        drive(`SRL, 32'h8000_0001, 32'h20);
        step();
        total_cnt++;
        if (w !== 32'h8000_0001) $display("FAIL srl_by_32: got %h want %h", w, 32'h8000_0001);
        else pass_cnt++;
    endtask

    task automatic test_compare_mul();
        drive(`SLT, 32'h8000_0000, 32'h1);
        step();
        total_cnt++;
        if (w !== 32'h1) $display("FAIL slt_neg: got %h want %h", w, 32'h1);
        else pass_cnt++;
        drive(`SLTU, 32'h8000_0000, 32'h1);
        step();
        total_cnt++;
        if (w !== 32'h0) $display("FAIL sltu: got %h want %h", w, 32'h0);
        else pass_cnt++;
        drive(`SLTU, 32'h1, 32'h8000_0000);
        step();
        total_cnt++;
        if (w !== 32'h1) $display("FAIL sltu_true: got %h want %h", w, 32'h1);
        else pass_cnt++;
        drive(`SLT, 32'h5, 32'h5);
        step();
        total_cnt++;
        if (w !== 32'h0) $display("FAIL slt_equal: got %h want %h", w, 32'h0);
        else pass_cnt++;
        drive(`MUL, 32'h0001_0000, 32'h0001_0001);
        step();
        total_cnt++;
        if (w !== 32'h0001_0000) $display("FAIL mul: got %h want %h", w, 32'h0001_0000);
        else pass_cnt++;
        drive(`MUL, 32'hFFFF_FFFF, 32'h3);
        step();
        total_cnt++;
        if (w !== 32'hFFFF_FFFD) $display("FAIL mul_neg: got %h want %h", w, 32'hFFFF_FFFD);
        else pass_cnt++;
        drive(`MOVX, 32'h1234_5678, 32'h9ABC_DEF0);
        step();
        total_cnt++;
        if (w !== 32'h1234_5678) $display("FAIL movx: got %h want %h", w, 32'h1234_5678);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        drive(`ADD, 32'h1, 32'h2);
        step();
        total_cnt++;
        if (w !== 32'h3) $display("FAIL b2b_add: got %h want %h", w, 32'h3);
        else pass_cnt++;
        drive(`MOVY, 32'h0, 32'hDEAD_BEEF);
        step();
        total_cnt++;
        if (w !== 32'hDEAD_BEEF) $display("FAIL b2b_movy: got %h want %h", w, 32'hDEAD_BEEF);
        else pass_cnt++;
        drive(7'h7F, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        total_cnt++;
        if (w !== 32'h0) $display("FAIL b2b_illegal: got %h want %h", w, 32'h0);
        else pass_cnt++;
        drive(`MOVY, 32'h0, 32'hCAFE_F00D);
        step();
        drive(7'h0D, 32'h1, 32'h1);
        step();
        total_cnt++;
        if (w !== 32'h0) $display("FAIL illegal_0d: got %h want %h", w, 32'h0);
        else pass_cnt++;
    endtask

    // Reset asserted with a live op must win, and w must hold while inputs change between edges.
    task automatic test_reset_priority();
        drive(`MOVY, 32'h0, 32'h5555_AAAA);
        step();
        rst_n = 1'b0;
        drive(`MOVY, 32'h0, 32'h1111_2222);
        step();
        total_cnt++;
        if (w !== 32'h0) $display("FAIL reset_priority: got %h want %h", w, 32'h0);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        drive(`MOVX, 32'h7777_7777, 32'h0);
        #3;
        total_cnt++;
        if (w !== 32'h1111_2222) $display("FAIL hold_between_edges: got %h want %h", w, 32'h1111_2222);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        op        = `ADD;
        x         = 32'h0;
        y         = 32'h0;
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_compare_mul();
        test_back_to_back();
        test_reset_priority();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
